// File: rtl/execute_mdu.sv
// execute_mdu: iterative radix-2 multiply/divide unit with architectural HI/LO for the execute stage.
// The divider exists only when EXECUTE_MDU_DIV_EN is defined; otherwise DIV/DIVU behave as NOP.
module execute_mdu #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_valid,
    input  logic [2:0]    i_con_op,
    input  logic [DW-1:0] i_data_a,
    input  logic [DW-1:0] i_data_b,
    input  logic [AW-1:0] i_addr_rd,
    input  logic          i_flush,
    output logic          o_stall,
    output logic          o_valid,
    output logic [DW-1:0] o_data_res,
    output logic [AW-1:0] o_addr_rd,
    output logic          o_con_regwrite,
    output logic [DW-1:0] o_hi,
    output logic [DW-1:0] o_lo
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;
    typedef enum logic [2:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTLO
    } op_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] acc_hi;
    logic [DW-1:0] acc_lo;
    logic [DW-1:0] opnd;
    logic          neg_q;
`ifdef EXECUTE_MDU_DIV_EN
    logic          is_div;
    logic          neg_r;
    logic          div_zero;
    logic [DW:0]   div_shift;
    logic [DW:0]   div_trial;
`endif

    op_t           op;
    logic          op_active;
    logic          op_signed;
    logic          a_neg;
    logic          b_neg;
    logic [DW-1:0] a_mag;
    logic [DW-1:0] b_mag;
    logic [DW:0]   mul_sum;
    logic [DW-1:0] step_hi;
    logic [DW-1:0] step_lo;
    logic [2*DW-1:0] prod;
    logic [DW-1:0] fix_hi;
    logic [DW-1:0] fix_lo;

    always_comb begin
        op        = op_t'(i_con_op);
        op_signed = 1'b0;
        op_active = i_valid && (op != OP_NOP);
        case (op)
            OP_MULT: op_signed = 1'b1;
`ifdef EXECUTE_MDU_DIV_EN
            OP_DIV:  op_signed = 1'b1;
`else
            OP_DIV, OP_DIVU: op_active = 1'b0;
`endif
            default: ;
        endcase
        a_neg = op_signed && i_data_a[DW-1];
        b_neg = op_signed && i_data_b[DW-1];
        a_mag = a_neg ? -i_data_a : i_data_a;
        b_mag = b_neg ? -i_data_b : i_data_b;
    end

    assign o_stall = i_nrst && !i_flush && (state != IDLE) && op_active;

    // One iteration: multiply adds then shifts right; divide shifts left then trial-subtracts.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        step_hi = mul_sum[DW:1];
        step_lo = {mul_sum[0], acc_lo[DW-1:1]};
`ifdef EXECUTE_MDU_DIV_EN
        div_shift = {acc_hi, acc_lo[DW-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (is_div) begin
            step_hi = div_trial[DW] ? div_shift[DW-1:0] : div_trial[DW-1:0];
            step_lo = {acc_lo[DW-2:0], ~div_trial[DW]};
        end
`endif
    end

    always_comb begin
        prod = {acc_hi, acc_lo};
        if (neg_q) begin
            prod = -prod;
        end
        fix_hi = prod[2*DW-1:DW];
        fix_lo = prod[DW-1:0];
`ifdef EXECUTE_MDU_DIV_EN
        // Divide by zero: quotient forced to all ones; remainder already equals the dividend.
        if (is_div) begin
            fix_lo = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
            fix_hi = neg_r ? -acc_hi : acc_hi;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state          <= IDLE;
            cnt            <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            opnd           <= '0;
            neg_q          <= 1'b0;
`ifdef EXECUTE_MDU_DIV_EN
            is_div         <= 1'b0;
            neg_r          <= 1'b0;
            div_zero       <= 1'b0;
`endif
            o_hi           <= '0;
            o_lo           <= '0;
            o_valid        <= 1'b0;
            o_data_res     <= '0;
            o_addr_rd      <= '0;
            o_con_regwrite <= 1'b0;
        end else begin
            o_valid        <= 1'b0;
            o_con_regwrite <= 1'b0;
            o_data_res     <= '0;
            o_addr_rd      <= '0;
            if (i_flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_valid) begin
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    acc_hi    <= '0;
                                    acc_lo    <= b_mag;
                                    opnd      <= a_mag;
                                    neg_q     <= a_neg ^ b_neg;
`ifdef EXECUTE_MDU_DIV_EN
                                    is_div    <= 1'b0;
`endif
                                    cnt       <= CW'(DW);
                                    state     <= BUSY;
                                    o_valid   <= 1'b1;
                                    o_addr_rd <= i_addr_rd;
                                end
`ifdef EXECUTE_MDU_DIV_EN
                                OP_DIV, OP_DIVU: begin
                                    acc_hi    <= '0;
                                    acc_lo    <= a_mag;
                                    opnd      <= b_mag;
                                    is_div    <= 1'b1;
                                    div_zero  <= (i_data_b == '0);
                                    neg_q     <= (a_neg ^ b_neg) && (i_data_b != '0);
                                    neg_r     <= a_neg;
                                    cnt       <= CW'(DW);
                                    state     <= BUSY;
                                    o_valid   <= 1'b1;
                                    o_addr_rd <= i_addr_rd;
                                end
`endif
                                OP_MFHI, OP_MFLO: begin
                                    o_valid        <= 1'b1;
                                    o_con_regwrite <= 1'b1;
                                    o_data_res     <= (op == OP_MFHI) ? o_hi : o_lo;
                                    o_addr_rd      <= i_addr_rd;
                                end
                                OP_MTLO: begin
                                    o_lo      <= i_data_a;
                                    o_valid   <= 1'b1;
                                    o_addr_rd <= i_addr_rd;
                                end
                                default: ;
                            endcase
                        end
                    end
                    BUSY: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        o_hi  <= fix_hi;
                        o_lo  <= fix_lo;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: randomized scoreboard bench for execute_mdu against an arithmetic reference model.
module tb_execute_mdu;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3;
    localparam logic [2:0] DIVU = 3'd4, MFHI = 3'd5, MFLO = 3'd6, MTLO = 3'd7;

    logic          i_clk = 1'b0;
    logic          i_nrst;
    logic          i_valid;
    logic [2:0]    i_con_op;
    logic [DW-1:0] i_data_a;
    logic [DW-1:0] i_data_b;
    logic [AW-1:0] i_addr_rd;
    logic          i_flush;
    logic          o_stall;
    logic          o_valid;
    logic [DW-1:0] o_data_res;
    logic [AW-1:0] o_addr_rd;
    logic          o_con_regwrite;
    logic [DW-1:0] o_hi;
    logic [DW-1:0] o_lo;

    execute_mdu #(.DW(DW), .AW(AW)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_valid(i_valid), .i_con_op(i_con_op),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_addr_rd(i_addr_rd), .i_flush(i_flush),
        .o_stall(o_stall), .o_valid(o_valid), .o_data_res(o_data_res), .o_addr_rd(o_addr_rd),
        .o_con_regwrite(o_con_regwrite), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 i_clk = ~i_clk;

    int unsigned ecount = 0;
    always @(posedge i_clk) ecount <= ecount + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic          regwrite;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: architectural HI/LO plus one pending result due at a given edge count.
    logic [DW-1:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
    bit            pend = 1'b0;
    int unsigned   done_edge = 0;
    int unsigned   last_waits;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void sync_model();
        if (pend && ecount >= done_edge) begin
            m_hi = p_hi;
            m_lo = p_lo;
            pend = 1'b0;
        end
    endfunction

    function automatic bit div_enabled();
`ifdef EXECUTE_MDU_DIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_active(input logic [2:0] op);
        if (op == NOP) return 1'b0;
        if ((op == DIV || op == DIVU) && !div_enabled()) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_accept(input logic [2:0] op, input logic [DW-1:0] a, b,
                                         input logic [AW-1:0] rd, input bit fl, input bit idle_pre);
        longint          sp;
        longint unsigned up;
        exp_t            e;
        if (fl) begin
            pend      = 1'b0;
            done_edge = ecount;
            return;
        end
        if (!idle_pre || !is_active(op)) return;
        e.data = '0; e.rd = rd; e.regwrite = 1'b0;
        case (op)
            MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p_hi = sp[63:32]; p_lo = sp[31:0];
            end
            MULTU: begin
                up = longint'({32'b0, a}) * longint'({32'b0, b});
                p_hi = up[63:32]; p_lo = up[31:0];
            end
            DIV: begin
                if (b == '0) begin
                    p_lo = '1; p_hi = a;
                end else begin
                    sp = longint'($signed(a)) / longint'($signed(b));
                    p_lo = sp[31:0];
                    sp = longint'($signed(a)) % longint'($signed(b));
                    p_hi = sp[31:0];
                end
            end
            DIVU: begin
                if (b == '0) begin
                    p_lo = '1; p_hi = a;
                end else begin
                    p_lo = a / b; p_hi = a % b;
                end
            end
            MFHI: begin e.data = m_hi; e.regwrite = 1'b1; end
            MFLO: begin e.data = m_lo; e.regwrite = 1'b1; end
            default: m_lo = a;
        endcase
        if (op == MULT || op == MULTU || op == DIV || op == DIVU) begin
            pend      = 1'b1;
            done_edge = ecount + DW + 1;
        end
        exp_q.push_back(e);
    endfunction

    // Present one instruction (called #1 after a rising edge); holds it while the model expects a stall.
    task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, b,
                         input logic [AW-1:0] rd, input bit fl);
        bit          exp_st, idle_pre;
        int unsigned waits = 0;
        i_valid = 1'b1; i_con_op = op; i_data_a = a; i_data_b = b; i_addr_rd = rd; i_flush = fl;
        forever begin
            sync_model();
            idle_pre = (ecount >= done_edge);
            exp_st   = !fl && !idle_pre && is_active(op);
            #1;
            chk("o_stall", 64'(o_stall), 64'(exp_st));
            if (!exp_st) break;
            waits++;
            if (waits > DW + 4) begin
                checks++; errors++;
                $display("FAIL stall_timeout: stalled %0d cycles, limit %0d", waits, DW + 4);
                break;
            end
            @(posedge i_clk); #1;
        end
        last_waits = waits;
        @(posedge i_clk); #1;
        model_accept(op, a, b, rd, fl, idle_pre);
        i_valid = 1'b0; i_con_op = NOP; i_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0; i_con_op = NOP; i_flush = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return DW'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every falling edge compare HI/LO with the model and pop one expectation per o_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_nrst) begin
                sync_model();
                chk("o_hi", 64'(o_hi), 64'(m_hi));
                chk("o_lo", 64'(o_lo), 64'(m_lo));
                if (o_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_valid: got o_valid=1 data=%h expected none", o_data_res);
                    end else begin
                        e = exp_q.pop_front();
                        chk("o_con_regwrite", 64'(o_con_regwrite), 64'(e.regwrite));
                        if (e.regwrite) begin
                            chk("o_data_res", 64'(o_data_res), 64'(e.data));
                            chk("o_addr_rd", 64'(o_addr_rd), 64'(e.rd));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rop;
        i_nrst = 1'b0; i_valid = 1'b1; i_con_op = MFLO; i_flush = 1'b0;
        i_data_a = 32'hDEAD_BEEF; i_data_b = 32'h1234; i_addr_rd = 5'd3;
        #2;
        chk("reset_stall", 64'(o_stall), 64'd0);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_data", 64'(o_data_res), 64'd0);
        chk("reset_addr", 64'(o_addr_rd), 64'd0);
        chk("reset_regwrite", 64'(o_con_regwrite), 64'd0);
        chk("reset_hilo", {o_hi, o_lo}, 64'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_nrst = 1'b1; i_valid = 1'b0; i_con_op = NOP;

        // Signed multiply: result lands exactly DW+1 edges after acceptance.
        issue(MULT, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 1'b0);
        repeat (DW) @(posedge i_clk);
        #1;
        chk("mult_not_yet", {o_hi, o_lo}, 64'd0);
        @(posedge i_clk); #1;
        chk("mult_hi", 64'(o_hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(o_lo), 64'hFFFF_FFFE);

`ifdef EXECUTE_MDU_DIV_EN
        issue(DIVU, 32'd100, 32'd7, 5'd0, 1'b0);
        issue(MFLO, '0, '0, 5'd9, 1'b0);
        chk("divu_stall_cycles", 64'(last_waits), 64'(DW + 1));
        idle(2);
        chk("divu_hi", 64'(o_hi), 64'd2);
        chk("divu_lo", 64'(o_lo), 64'd14);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
        idle(DW + 2);
        chk("div_neg_lo", 64'(o_lo), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(o_hi), 64'hFFFF_FFFF);
        issue(DIVU, 32'd5, 32'd0, 5'd0, 1'b0);
        idle(DW + 2);
        chk("div0_lo", 64'(o_lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(o_hi), 64'd5);
`else
        issue(MTLO, 32'h55, '0, 5'd0, 1'b0);
        issue(DIV, 32'd9, 32'd3, 5'd4, 1'b0);
        idle(2);
        chk("div_off_lo", 64'(o_lo), 64'h55);
        issue(MULT, 32'd6, 32'd7, 5'd0, 1'b0);
        issue(DIV, 32'd9, 32'd3, 5'd4, 1'b0);
        idle(DW + 2);
        chk("div_off_busy_lo", 64'(o_lo), 64'd42);
`endif

        // Flush mid-multiply: HI/LO keep the values from before the MULTU.
        issue(MTLO, 32'hA5A5_0001, '0, 5'd0, 1'b0);
        issue(MULTU, 32'd3, 32'd4, 5'd0, 1'b0);
        idle(9);
        issue(MFLO, '0, '0, 5'd7, 1'b1);
        issue(MFHI, '0, '0, 5'd8, 1'b0);
        idle(DW + 2);
        chk("flush_lo_kept", 64'(o_lo), 64'hA5A5_0001);
        issue(MFLO, '0, '0, 5'd10, 1'b0);

        // Asynchronous reset during a busy multiply.
        issue(MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5'd2, 1'b0);
        idle(5);
        #2;
        i_nrst = 1'b0;
        m_hi = '0; m_lo = '0; pend = 1'b0; done_edge = 0; exp_q.delete();
        i_valid = 1'b1; i_con_op = MFLO;
        #1;
        chk("arst_stall", 64'(o_stall), 64'd0);
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_hilo", {o_hi, o_lo}, 64'd0);
        @(posedge i_clk); #1;
        i_nrst = 1'b1; i_valid = 1'b0; i_con_op = NOP;
        idle(DW + 4);
        chk("arst_no_write", {o_hi, o_lo}, 64'd0);

        for (int i = 0; i < 250; i++) begin
            rop = 3'($urandom_range(0, 7));
            issue(rop, rnd_val(), rnd_val(), 5'($urandom), ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
        end
        idle(DW + 4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding results expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
